peridot_swi_flashread: RTL and testbench
========================================

// Module: peridot_swi_flashread
// PURPOSE
//   Autonomous SPI-Flash read sequencer that sits directly upstream of the SWI boot-flash SPI register (reg05).
//   Drives that register as an Avalon-MM master to issue a READ command, 24-bit address, optional dummy bytes
//   and LEN data cycles, then streams received bytes out on an Avalon-ST source. Frees the CPU from per-byte polling.
// PARAMETERS
//   READ_CMD      8'h03   flash read opcode (8'h0B for fast read)
//   DUMMY_BYTES   0       dummy bytes sent after address, 0..7 (1 for fast read)
//   SWI_SPI_INDEX 3'd5    word index of the SWI SPI register driven on avm_address
// PORTS
//   csi_clk         in   1   clock
//   rsi_reset_n     in   1   asynchronous active-low reset
//   avs_address     in   2   control slave word address
//   avs_read        in   1   control slave read strobe (zero wait, combinational readdata)
//   avs_readdata    out  32  control slave read data
//   avs_write       in   1   control slave write strobe
//   avs_writedata   in   32  control slave write data
//   ins_irq         out  1   done interrupt (done & irqena)
//   avm_address     out  3   fixed SWI_SPI_INDEX
//   avm_read        out  1   master read (poll SWI SPI register)
//   avm_write       out  1   master write (start byte / release select)
//   avm_writedata   out  32  {16'b0, 6'b0, start, select, txdata}, irqena bit15 always 0
//   avm_readdata    in   32  bit9 ready, bit7-0 rxdata; valid in cycle avm_read & !avm_waitrequest
//   avm_waitrequest in   1   master stall; tie 0 for the plain SWI slave
//   aso_valid       out  1   read byte valid
//   aso_data        out  8   read byte
//   aso_ready       in   1   sink ready
// BEHAVIOUR
// - Slave regs: 0 ADDR[23:0] RW; 1 LEN[15:0] RW (data byte count); 2 CTRL: W bit0 start, bit1 done W1C, bit2 irqena RW,
//   bit3 abort; R {bit0 busy, bit1 done, bit2 irqena}; 3 REMAIN[15:0] RO. Writes to ADDR/LEN while busy ignored.
// - Reset: all regs 0, FSM IDLE, avm_read/avm_write/aso_valid/ins_irq 0, avm_writedata 0.
// - Master: avm_read/avm_write and avm_writedata held stable until sampled with avm_waitrequest=0; never both high.
// - Byte sequence: READ_CMD, ADDR[23:16], ADDR[15:8], ADDR[7:0], DUMMY_BYTES x 8'h00, LEN x 8'h00 (data phase).
// - FSM: IDLE -start&busy=0-> if LEN=0: set done, stay IDLE (no SPI access); else SEND.
//   SEND: write {start=1, select=1, txdata=next byte}; accepted -> POLL.
//   POLL: read repeatedly until readdata[9]=1 (first read may issue the cycle after SEND acceptance).
//     Header/dummy byte -> SEND next; data byte -> latch readdata[7:0] into aso_data, aso_valid=1 -> PUSH.
//   PUSH: hold aso_valid/aso_data until aso_ready; on handshake REMAIN-=1; REMAIN=0 or abort pending -> RELEASE, else SEND.
//   RELEASE: write {start=0, select=0, txdata=0}; accepted -> set done, IDLE.
// - busy=1 from start acceptance until RELEASE write accepted. start while busy ignored.
// - REMAIN loaded with LEN at start; 16-bit, LEN=16'hFFFF max; no wrap.
// - Abort: sets pending flag; current byte completes (POLL/PUSH finish), then RELEASE; done set; REMAIN keeps residual.
//   Abort in IDLE: no effect.
// - done W1C and FSM set in same cycle: set wins. ins_irq = done & irqena, registered.
// - Backpressure: aso_ready=0 stalls in PUSH with select held low; no further SPI clocks.
// - Async reset mid-transfer: FSM to IDLE immediately; select not released by this block (SWI shares the reset).
// - Header latency: each byte = 1 write + >=1 poll reads; first aso_valid no earlier than cycle 2*(4+DUMMY_BYTES)+2.
// TESTING
//   ADDR=0x012345, LEN=4, start; flash model returns A0..A3 -> writes 03,01,23,45,00x4 with select=1;
//     aso bytes A0,A1,A2,A3; final write 0x000; done=1, busy=0.
//   LEN=0, start -> no avm access; done=1 next cycle; ins_irq=1 if irqena=1.
//   LEN=3, aso_ready low 20 cycles on byte 2 -> aso_data/valid stable; no avm_write during stall; stream completes.
//   LEN=100, abort after byte 5 accepted -> byte 6 completes, RELEASE write, done=1, REMAIN=94.
//   avm_waitrequest random 50% -> identical byte sequence and output stream as with waitrequest=0.
//   rsi_reset_n low during POLL -> next cycle busy=0, avm_read=0, aso_valid=0; new start runs clean transfer.

Source files
------------

// File: rtl/peridot_swi_flashread_if.sv
// ---------------------------------------------------------------------------
// peridot_swi_flashread_if : control slave, SWI SPI master and byte-stream bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface peridot_swi_flashread_if;
  // control slave (CPU side)
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  // master towards the SWI SPI register
  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  // byte stream source
  logic        aso_valid;
  logic [7:0]  aso_data;
  logic        aso_ready;

  // slave: the sequencer's view of every bus it sits on
  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata,
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest,
    output aso_valid, aso_data,
    input  aso_ready
  );

  // master: the surrounding system (CPU, SWI register, stream sink)
  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata,
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest,
    input  aso_valid, aso_data,
    output aso_ready
  );
endinterface

`default_nettype wire

// File: rtl/peridot_swi_flashread.sv
// ---------------------------------------------------------------------------
// peridot_swi_flashread : SPI-flash read sequencer driving the SWI SPI register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module peridot_swi_flashread #(
  parameter logic [7:0] READ_CMD      = 8'h03,
  parameter int         DUMMY_BYTES   = 0,
  parameter logic [2:0] SWI_SPI_INDEX = 3'd5
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset_n,
  peridot_swi_flashread_if.slave  bus,
  output logic                    ins_irq
);

  localparam logic [3:0]  HDR_BYTES = 4'(4 + DUMMY_BYTES);
  localparam logic [31:0] SEL_START = 32'h0000_0300;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    POLL    = 3'd2,
    PUSH    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t      state;
  logic [23:0] addr;
  logic [15:0] len;
  logic [15:0] remain;
  logic        done;
  logic        irqena;
  logic        abort_pend;
  logic [3:0]  byte_idx;

  logic        busy;
  logic        ctrl_wr;
  logic        start_req;
  logic        done_clr;
  logic        abort_req;
  logic        unused_ok;

  assign busy      = (state != IDLE);
  assign ctrl_wr   = bus.avs_write && (bus.avs_address == 2'd2);
  assign start_req = ctrl_wr && bus.avs_writedata[0];
  assign done_clr  = ctrl_wr && bus.avs_writedata[1];
  assign abort_req = ctrl_wr && bus.avs_writedata[3];

  assign bus.avm_address = SWI_SPI_INDEX;
  assign unused_ok = &{1'b0, bus.avs_read, bus.avs_writedata[31:24],
                       bus.avm_readdata[31:10], bus.avm_readdata[8]};

  // Header byte for a given position; dummy positions transmit zero.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [23:0] a);
    case (idx)
      4'd0:    hdr_byte = READ_CMD;
      4'd1:    hdr_byte = a[23:16];
      4'd2:    hdr_byte = a[15:8];
      4'd3:    hdr_byte = a[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    bus.avs_readdata = 32'h0;
    case (bus.avs_address)
      2'd0: bus.avs_readdata = {8'h00, addr};
      2'd1: bus.avs_readdata = {16'h0000, len};
      2'd2: bus.avs_readdata = {29'h0, irqena, done, busy};
      2'd3: bus.avs_readdata = {16'h0000, remain};
      default: bus.avs_readdata = 32'h0;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state             <= IDLE;
      addr              <= 24'h0;
      len               <= 16'h0;
      remain            <= 16'h0;
      done              <= 1'b0;
      irqena            <= 1'b0;
      abort_pend        <= 1'b0;
      byte_idx          <= 4'h0;
      ins_irq           <= 1'b0;
      bus.avm_read      <= 1'b0;
      bus.avm_write     <= 1'b0;
      bus.avm_writedata <= 32'h0;
      bus.aso_valid     <= 1'b0;
      bus.aso_data      <= 8'h00;
    end else begin
      if (bus.avs_write && !busy) begin
        if (bus.avs_address == 2'd0) addr <= bus.avs_writedata[23:0];
        if (bus.avs_address == 2'd1) len  <= bus.avs_writedata[15:0];
      end
      if (ctrl_wr)           irqena     <= bus.avs_writedata[2];
      if (done_clr)          done       <= 1'b0;
      if (abort_req && busy) abort_pend <= 1'b1;
      ins_irq <= done && irqena;

      // Assignments below override the W1C / abort updates above when both fire.
      case (state)
        IDLE: begin
          if (start_req) begin
            if (len == 16'h0) begin
              done <= 1'b1;
            end else begin
              remain            <= len;
              byte_idx          <= 4'h0;
              bus.avm_writedata <= SEL_START | {24'h0, READ_CMD};
              bus.avm_write     <= 1'b1;
              state             <= SEND;
            end
          end
        end

        SEND: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_write <= 1'b0;
            bus.avm_read  <= 1'b1;
            state         <= POLL;
          end
        end

        POLL: begin
          if (!bus.avm_waitrequest && bus.avm_readdata[9]) begin
            bus.avm_read <= 1'b0;
            if (byte_idx == HDR_BYTES) begin
              bus.aso_data  <= bus.avm_readdata[7:0];
              bus.aso_valid <= 1'b1;
              state         <= PUSH;
            end else if (abort_pend) begin
              bus.avm_writedata <= 32'h0;
              bus.avm_write     <= 1'b1;
              state             <= RELEASE;
            end else begin
              byte_idx          <= byte_idx + 4'd1;
              bus.avm_writedata <= SEL_START | {24'h0, hdr_byte(byte_idx + 4'd1, addr)};
              bus.avm_write     <= 1'b1;
              state             <= SEND;
            end
          end
        end

        PUSH: begin
          if (bus.aso_ready) begin
            bus.aso_valid <= 1'b0;
            remain        <= remain - 16'd1;
            bus.avm_write <= 1'b1;
            if ((remain == 16'd1) || abort_pend) begin
              bus.avm_writedata <= 32'h0;
              state             <= RELEASE;
            end else begin
              bus.avm_writedata <= SEL_START;
              state             <= SEND;
            end
          end
        end

        RELEASE: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_write <= 1'b0;
            done          <= 1'b1;
            abort_pend    <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_peridot_swi_flashread.sv
// ---------------------------------------------------------------------------
// tb_peridot_swi_flashread : directed bench with an SWI SPI register model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_peridot_swi_flashread;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  always #5 clk = ~clk;

  peridot_swi_flashread_if bus();

  peridot_swi_flashread #(
    .READ_CMD(8'h03), .DUMMY_BYTES(0), .SWI_SPI_INDEX(3'd5)
  ) dut (
    .csi_clk(clk), .rsi_reset_n(rst_n), .bus(bus), .ins_irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SWI SPI register model: ready drops for two cycles after each start write
  logic        m_ready;
  logic [7:0]  m_rx;
  int          m_cnt;
  int          m_nbyte;
  logic [7:0]  m_base = 8'hA0;
  logic        wreq = 1'b0;
  logic        wreq_rand_en = 1'b0;
  logic [31:0] wq[$];
  logic [7:0]  bq[$];
  int wr_count = 0, acc_count = 0, both_viol = 0, hold_viol = 0;

  assign bus.avm_waitrequest = wreq;
  assign bus.avm_readdata    = {22'h0, m_ready, 1'b0, m_rx};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1; m_rx <= 8'h00; m_cnt <= 0; m_nbyte <= 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_ready <= 1'b1;
      end
      if (bus.avm_write && !wreq) begin
        wq.push_back(bus.avm_writedata);
        wr_count++;
        acc_count++;
        if (bus.avm_writedata[9]) begin
          m_ready <= 1'b0;
          m_cnt   <= 2;
          m_rx    <= (m_nbyte >= 4) ? m_base + 8'(m_nbyte - 4) : 8'hFF;
          m_nbyte <= m_nbyte + 1;
        end else begin
          m_nbyte <= 0;
        end
      end
      if (bus.avm_read && !wreq) acc_count++;
    end
  end

  always @(negedge clk) wreq = wreq_rand_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // Protocol monitor: no read+write together, held stable while stalled
  logic        pw = 1'b0, pr = 1'b0;
  logic [31:0] pwd = 32'h0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.avm_read && bus.avm_write) both_viol++;
      if (pw && !(bus.avm_write && bus.avm_writedata == pwd)) hold_viol++;
      if (pr && !bus.avm_read) hold_viol++;
      pw  = bus.avm_write && wreq;
      pr  = bus.avm_read && wreq;
      pwd = bus.avm_writedata;
    end else begin
      pw = 1'b0; pr = 1'b0;
    end
  end

  always @(posedge clk)
    if (rst_n && bus.aso_valid && bus.aso_ready) bq.push_back(bus.aso_data);

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    #1 d = bus.avs_readdata;
    bus.avs_read = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic [31:0] s;
    int n = 0;
    do begin
      @(negedge clk);
      rd(2'd2, s);
      n++;
    end while (s[0] && n < budget);
    check({tag, "_idle"}, {31'h0, s[0]}, 32'h0);
  endtask

  task automatic start_xfer(input logic [23:0] a, input logic [15:0] n, input logic [7:0] base);
    m_base = base;
    wq.delete(); bq.delete();
    wr(2'd0, {8'h00, a});
    wr(2'd1, {16'h0, n});
    wr(2'd2, 32'h1);
  endtask

  task automatic check_seq(input string tag, input logic [23:0] a, input int n, input logic [7:0] base);
    logic [31:0] e;
    check({tag, "_nwr"}, wq.size(), 4 + n + 1);
    for (int k = 0; k < wq.size() && k < 4 + n + 1; k++) begin
      if (k == 0)          e = 32'h303;
      else if (k == 1)     e = {24'h3, a[23:16]};
      else if (k == 2)     e = {24'h3, a[15:8]};
      else if (k == 3)     e = {24'h3, a[7:0]};
      else if (k == 4 + n) e = 32'h000;
      else                 e = 32'h300;
      check($sformatf("%s_w%0d", tag, k), wq[k], e);
    end
    check({tag, "_nbytes"}, bq.size(), n);
    for (int k = 0; k < bq.size() && k < n; k++)
      check($sformatf("%s_b%0d", tag, k), {24'h0, bq[k]}, {24'h0, 8'(base + 8'(k))});
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int n, unstable, w0, a0;
    logic [7:0] hold_d;

    bus.avs_address = 2'd0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_writedata = 32'h0; bus.aso_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), d);
      check($sformatf("rst_reg%0d", r), d, 32'h0);
    end
    check("rst_avm_rd", {31'h0, bus.avm_read}, 32'h0);
    check("rst_avm_wr", {31'h0, bus.avm_write}, 32'h0);
    check("rst_wdata", bus.avm_writedata, 32'h0);
    check("rst_aso_valid", {31'h0, bus.aso_valid}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("avm_addr", {29'h0, bus.avm_address}, 32'h5);

    // basic read of 4 bytes
    start_xfer(24'h012345, 16'd4, 8'hA0);
    wait_done("t1", 400);
    check_seq("t1", 24'h012345, 4, 8'hA0);
    rd(2'd2, d); check("t1_ctrl", d, 32'h2);
    rd(2'd3, d); check("t1_remain", d, 32'h0);
    wr(2'd2, 32'h2);
    rd(2'd2, d); check("t1_w1c", d, 32'h0);

    // LEN=0: done immediately, no SPI access, interrupt one cycle later
    wr(2'd1, 32'h0);
    a0 = acc_count;
    wr(2'd2, 32'h5);
    rd(2'd2, d); check("t2_ctrl", d, 32'h6);
    @(negedge clk);
    check("t2_irq", {31'h0, irq}, 32'h1);
    check("t2_noacc", acc_count, a0);
    wr(2'd2, 32'h6);
    @(negedge clk);
    check("t2_irq_clr", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h0);

    // backpressure on byte 2
    start_xfer(24'h00ABCD, 16'd3, 8'hB0);
    n = 0;
    while (!(bus.aso_valid && bq.size() == 1) && n < 300) begin @(negedge clk); n++; end
    check("t3_reach", {31'h0, bus.aso_valid}, 32'h1);
    bus.aso_ready = 1'b0;
    hold_d = bus.aso_data;
    w0 = wr_count;
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.aso_valid || bus.aso_data != hold_d) unstable++;
    end
    check("t3_stable", unstable, 0);
    check("t3_held_byte", {24'h0, hold_d}, 32'hB1);
    check("t3_no_wr", wr_count, w0);
    bus.aso_ready = 1'b1;
    wait_done("t3", 400);
    check_seq("t3", 24'h00ABCD, 3, 8'hB0);
    wr(2'd2, 32'h2);

    // abort after byte 5; ADDR/LEN writes while busy are ignored
    start_xfer(24'h000100, 16'd100, 8'h10);
    wr(2'd0, 32'h00FFFFFF);
    wr(2'd1, 32'h7);
    n = 0;
    while (bq.size() < 5 && n < 1000) begin @(negedge clk); n++; end
    check("t4_reach", bq.size(), 5);
    wr(2'd2, 32'h8);
    wait_done("t4", 400);
    check("t4_nbytes", bq.size(), 6);
    if (bq.size() == 6) check("t4_b5", {24'h0, bq[5]}, 32'h15);
    check("t4_nwr", wq.size(), 11);
    if (wq.size() > 0) check("t4_release", wq[wq.size()-1], 32'h0);
    rd(2'd3, d); check("t4_remain", d, 32'd94);
    rd(2'd2, d); check("t4_ctrl", d, 32'h2);
    rd(2'd0, d); check("t4_addr_kept", d, 32'h000100);
    rd(2'd1, d); check("t4_len_kept", d, 32'd100);
    wr(2'd2, 32'h2);

    // random waitrequest gives the same transaction
    wreq_rand_en = 1'b1;
    start_xfer(24'h012345, 16'd4, 8'hA0);
    wait_done("t5", 1000);
    wreq_rand_en = 1'b0;
    check_seq("t5", 24'h012345, 4, 8'hA0);
    wr(2'd2, 32'h2);

    // reset while polling, then a clean transfer
    start_xfer(24'h012345, 16'd4, 8'hC0);
    n = 0;
    while (!bus.avm_read && n < 100) begin @(negedge clk); n++; end
    check("t6_reach", {31'h0, bus.avm_read}, 32'h1);
    rst_n = 1'b0;
    #2;
    check("t6_avm_rd", {31'h0, bus.avm_read}, 32'h0);
    check("t6_avm_wr", {31'h0, bus.avm_write}, 32'h0);
    check("t6_aso_valid", {31'h0, bus.aso_valid}, 32'h0);
    rd(2'd2, d); check("t6_ctrl", d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start_xfer(24'h00FF00, 16'd2, 8'h55);
    wait_done("t6", 400);
    check_seq("t6", 24'h00FF00, 2, 8'h55);

    check("both_rd_wr", both_viol, 0);
    check("hold_stable", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
